// File: rtl/cb_dinb_seq_pkg.sv
// -----------------------------------------------------------------------------
// cb_dinb_seq_pkg
// Shared definitions for the covariance-block port-B write sequencer:
//   - 2-bit direction codes, using the same encoding the lane mapper decodes
//   - sequencer state encoding
//   - NEW-mode lane masks for the 4-lane configuration
//   - map_dir(): folds the unused IDLE direction code onto POS
// -----------------------------------------------------------------------------
package cb_dinb_seq_pkg;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_POS  = 2'b01;
   localparam logic [1:0] DIR_NEG  = 2'b10;
   localparam logic [1:0] DIR_NEW  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // NEW mode writes only one half of the row: lk0=1 selects lanes 0-1,
   // lk0=0 selects lanes 2-3.
   localparam logic [3:0] NEW_MASK_LK1 = 4'b0011;
   localparam logic [3:0] NEW_MASK_LK0 = 4'b1100;

   // A command carrying the IDLE code is not meaningful to the mapper, so it
   // is run as a plain ascending (POS) write.
   function automatic logic [1:0] map_dir(input logic [1:0] dir);
      return (dir == DIR_IDLE) ? DIR_POS : dir;
   endfunction

endpackage

// File: rtl/cb_dinb_seq_addr_gen.sv
// -----------------------------------------------------------------------------
// cb_addr_gen
// Row address generator: loads a base address, then steps by +1 or -1 on
// each request. Arithmetic is modulo 2^ADDR_W, so it wraps silently.
// Ports:
//   clk     in   clock
//   i_srst  in   synchronous active-high reset (address cleared to 0)
//   i_load  in   load i_base (takes priority over i_step)
//   i_base  in   base address
//   i_step  in   advance one row
//   i_down  in   1 = step downward, 0 = step upward
//   o_addr  out  current address
// -----------------------------------------------------------------------------
module cb_addr_gen #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              i_srst,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_base,
   input  logic              i_step,
   input  logic              i_down,
   output logic [ADDR_W-1:0] o_addr
);

   logic [ADDR_W-1:0] r_addr;

   always_ff @(posedge clk) begin
      if (i_srst) begin
         r_addr <= '0;
      end else if (i_load) begin
         r_addr <= i_base;
      end else if (i_step) begin
         r_addr <= i_down ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
      end
   end

   assign o_addr = r_addr;

endmodule

// File: rtl/cb_dinb_seq.sv
// -----------------------------------------------------------------------------
// cb_dinb_seq
// Covariance-block BRAM port-B write sequencer. Takes one command (direction,
// lane half, base address, row count), then consumes the C-result stream one
// row per handshake. It steers the registered lane mapper (CB_dinb_sel,
// l_k_0) and issues the port-B write strobe one cycle after each beat so the
// strobe lines up with the mapper's registered data.
// Ports:
//   clk, sys_rst              clock, synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (ready only in IDLE)
//   cmd_dir, cmd_lk0          direction code, NEW-mode lane half
//   cmd_base, cmd_rows        first row address, number of rows
//   c_valid / c_ready         C-row handshake (ready only in RUN)
//   CB_dinb_sel, l_k_0        mapper controls (registered)
//   CB_enb, CB_web, CB_addrb  port-B write strobe (registered)
//   done                      one-cycle completion pulse
// -----------------------------------------------------------------------------
module cb_dinb_seq
   import cb_dinb_seq_pkg::*;
#(
   parameter int L      = 4,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_dir,
   input  logic              cmd_lk0,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [CNT_W-1:0]  cmd_rows,
   input  logic              c_valid,
   output logic              c_ready,
   output logic [1:0]        CB_dinb_sel,
   output logic              l_k_0,
   output logic              CB_enb,
   output logic [L-1:0]      CB_web,
   output logic [ADDR_W-1:0] CB_addrb,
   output logic              done
);

   state_t            r_state;
   state_t            w_state_next;
   logic              w_cmd_ready;
   logic              w_c_ready;
   logic              w_done;
   logic              w_accept;
   logic              w_beat;

   logic [1:0]        r_dir;
   logic              r_lk0;
   logic [CNT_W-1:0]  r_remain;

   logic [1:0]        r_sel;
   logic              r_lk;
   logic              r_enb;
   logic [L-1:0]      r_web;
   logic [ADDR_W-1:0] r_addrb;

   logic [ADDR_W-1:0] w_addr;
   logic [L-1:0]      w_new_mask;

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cmd_ready  = 1'b0;
      w_c_ready    = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cmd_ready = 1'b1;
            if (cmd_valid) begin
               // A zero-row command still reports completion via DRAIN.
               w_state_next = (cmd_rows != '0) ? ST_RUN : ST_DRAIN;
            end
         end
         ST_RUN: begin
            w_c_ready = 1'b1;
            if (c_valid && (r_remain == CNT_W'(1))) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The final strobe is on the bus this cycle, so done coincides.
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign w_accept = w_cmd_ready & cmd_valid;
   assign w_beat   = w_c_ready & c_valid;

   // ---------------------------------------------------------------------
   // Command latch and rows-remaining counter
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         r_dir    <= DIR_IDLE;
         r_lk0    <= 1'b0;
         r_remain <= '0;
      end else if (w_accept) begin
         r_dir    <= map_dir(cmd_dir);
         r_lk0    <= cmd_lk0;
         r_remain <= cmd_rows;
      end else if (w_beat) begin
         r_remain <= r_remain - CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Row address
   // ---------------------------------------------------------------------
   cb_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk    (clk),
      .i_srst (sys_rst),
      .i_load (w_accept),
      .i_base (cmd_base),
      .i_step (w_beat),
      .i_down (r_dir == DIR_NEG),
      .o_addr (w_addr)
   );

   // ---------------------------------------------------------------------
   // NEW-mode lane mask
   // ---------------------------------------------------------------------
   generate
      if (L == 4) begin : g_mask4
         assign w_new_mask = r_lk0 ? NEW_MASK_LK1 : NEW_MASK_LK0;
      end else begin : g_maskn
         // Generic split: lower half of the lanes for lk0=1, upper half else.
         for (genvar gi = 0; gi < L; gi++) begin : g_lane
            assign w_new_mask[gi] = r_lk0 ? (gi < L/2) : (gi >= L/2);
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Mapper controls: driven with the command's direction for exactly the
   // cycles the sequencer spends in RUN. Keying off the next state lets the
   // value appear the cycle after accept and drop as RUN is left.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         r_sel <= DIR_IDLE;
         r_lk  <= 1'b0;
      end else if (w_state_next == ST_RUN) begin
         r_sel <= w_accept ? map_dir(cmd_dir) : r_dir;
         r_lk  <= w_accept ? cmd_lk0 : r_lk0;
      end else begin
         r_sel <= DIR_IDLE;
         r_lk  <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Write strobe, one cycle behind the beat to match the mapper register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         r_enb   <= 1'b0;
         r_web   <= '0;
         r_addrb <= '0;
      end else begin
         r_enb   <= w_beat;
         r_addrb <= w_beat ? w_addr : '0;
         if (!w_beat) begin
            r_web <= '0;
         end else if (r_dir == DIR_NEW) begin
            r_web <= w_new_mask;
         end else begin
            r_web <= '1;
         end
      end
   end

   assign cmd_ready   = w_cmd_ready;
   assign c_ready     = w_c_ready;
   assign done        = w_done;
   assign CB_dinb_sel = r_sel;
   assign l_k_0       = r_lk;
   assign CB_enb      = r_enb;
   assign CB_web      = r_web;
   assign CB_addrb    = r_addrb;

endmodule

// File: tb/tb_cb_dinb_seq.sv
// -----------------------------------------------------------------------------
// tb_cb_dinb_seq
// Self-checking bench for cb_dinb_seq. Each command is run against a
// reference that derives, from the handshake rules, which cycles carry
// beats, where each strobe lands, when done pulses and when the sequencer is
// ready again; every output is compared every cycle. A table of directed
// commands also carries expected strobe counts/addresses, followed by
// hand-written reset and busy-ignore sequences and random commands.
// -----------------------------------------------------------------------------
module tb_cb_dinb_seq;

   localparam int L      = 4;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = 8;
   localparam int MAXP   = 160;

   logic              clk;
   logic              sys_rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_dir;
   logic              cmd_lk0;
   logic [ADDR_W-1:0] cmd_base;
   logic [CNT_W-1:0]  cmd_rows;
   logic              c_valid;
   logic              c_ready;
   logic [1:0]        CB_dinb_sel;
   logic              l_k_0;
   logic              CB_enb;
   logic [L-1:0]      CB_web;
   logic [ADDR_W-1:0] CB_addrb;
   logic              done;

   cb_dinb_seq #(
      .L      (L),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .sys_rst     (sys_rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_dir     (cmd_dir),
      .cmd_lk0     (cmd_lk0),
      .cmd_base    (cmd_base),
      .cmd_rows    (cmd_rows),
      .c_valid     (c_valid),
      .c_ready     (c_ready),
      .CB_dinb_sel (CB_dinb_sel),
      .l_k_0       (l_k_0),
      .CB_enb      (CB_enb),
      .CB_web      (CB_web),
      .CB_addrb    (CB_addrb),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  dir;
      logic        lk0;
      logic [9:0]  base;
      logic [7:0]  rows;
      logic [15:0] pat;    // c_valid per cycle after accept, LSB first, then 1s
      int          n;      // expected number of strobes
      logic [9:0]  first;  // expected first strobe address
      logic [9:0]  last;   // expected last strobe address
      logic [3:0]  web;    // expected write mask on the strobes
      logic [1:0]  sel;    // expected mapper select while running
   } vec_t;

   vec_t tbl[8];

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   vld[MAXP];

   int         st_n;
   logic [9:0] st_first;
   logic [9:0] st_last;
   logic [3:0] st_web;
   logic [1:0] st_sel;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Run one command from the idle state and compare all outputs each cycle.
   task automatic run_cmd(input logic [1:0] dir, input logic lk0, input logic [9:0] base,
                          input logic [7:0] rows, input bit hold, input string tag);
      logic [1:0]  mdir;
      logic [3:0]  mask;
      int          beats;
      int          last;
      bit          beat_at[MAXP];
      logic [9:0]  baddr[MAXP];
      logic [20:0] exp_v;
      logic [20:0] act_v;
      bit          e_run;
      mdir  = (dir == 2'b00) ? 2'b01 : dir;
      mask  = (mdir == 2'b11) ? (lk0 ? 4'b0011 : 4'b1100) : 4'b1111;
      beats = 0;
      last  = 0;
      for (int o = 0; o < MAXP; o++) begin
         beat_at[o] = 1'b0;
         baddr[o]   = '0;
      end
      // Offset o = cycles after the accept cycle; c_valid at offset o is vld[o-1].
      if (rows != 0) begin
         for (int o = 1; o < MAXP - 3 && beats < int'(rows); o++) begin
            if (vld[o-1]) begin
               beat_at[o] = 1'b1;
               baddr[o]   = (mdir == 2'b10) ? 10'(int'(base) - beats) : 10'(int'(base) + beats);
               beats++;
               if (beats == int'(rows)) last = o;
            end
         end
         if (last == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: reference ran out of cycles", tag);
            return;
         end
      end
      st_n = 0; st_first = '0; st_last = '0; st_web = '0; st_sel = '0;
      for (int o = 0; o <= last + 2; o++) begin
         @(negedge clk);
         e_run = (rows != 0) && (o >= 1) && (o <= last);
         exp_v = {(o == 0) || (o >= last + 2),
                  e_run,
                  e_run ? mdir : 2'b00,
                  e_run ? lk0 : 1'b0,
                  (o >= 1) && beat_at[o-1],
                  ((o >= 1) && beat_at[o-1]) ? mask : 4'b0000,
                  (o >= 1) ? baddr[o-1] : 10'd0,
                  (o == last + 1)};
         act_v = {cmd_ready, c_ready, CB_dinb_sel, l_k_0, CB_enb, CB_web, CB_addrb, done};
         chk($sformatf("%s off%0d {crdy,cvrdy,sel,lk,enb,web,addr,done}", tag, o),
             32'(act_v), 32'(exp_v));
         if (CB_enb) begin
            if (st_n == 0) st_first = CB_addrb;
            st_last = CB_addrb;
            st_web  = CB_web;
            st_n++;
         end
         if (o == 1) st_sel = CB_dinb_sel;
         // drive the inputs for this cycle
         if (o == 0) begin
            cmd_valid = 1'b1;
            cmd_dir   = dir;
            cmd_lk0   = lk0;
            cmd_base  = base;
            cmd_rows  = rows;
            c_valid   = 1'b0;
         end else if (o <= last + 1) begin
            cmd_valid = hold;
            if (hold) begin
               cmd_dir  = ~dir;
               cmd_lk0  = ~lk0;
               cmd_base = ~base;
               cmd_rows = 8'd7;
            end
            c_valid = vld[o-1];
         end else begin
            cmd_valid = 1'b0;
            c_valid   = 1'b0;
         end
      end
   endtask

   initial begin
      //           dir    lk0   base     rows  pat        n  first    last      web      sel
      tbl[0] = '{2'b01, 1'b0, 10'd5,    8'd3, 16'hFFFF, 3, 10'd5,    10'd7,    4'hF, 2'b01};
      tbl[1] = '{2'b10, 1'b0, 10'd2,    8'd4, 16'hFFFF, 4, 10'd2,    10'd1023, 4'hF, 2'b10};
      tbl[2] = '{2'b11, 1'b1, 10'd9,    8'd2, 16'hFFFF, 2, 10'd9,    10'd10,   4'h3, 2'b11};
      tbl[3] = '{2'b11, 1'b0, 10'd9,    8'd2, 16'hFFFF, 2, 10'd9,    10'd10,   4'hC, 2'b11};
      tbl[4] = '{2'b01, 1'b0, 10'd0,    8'd3, 16'hFFF9, 3, 10'd0,    10'd2,    4'hF, 2'b01};
      tbl[5] = '{2'b01, 1'b0, 10'd33,   8'd0, 16'hFFFF, 0, 10'd0,    10'd0,    4'h0, 2'b00};
      tbl[6] = '{2'b00, 1'b1, 10'd1022, 8'd4, 16'hFFFF, 4, 10'd1022, 10'd1,    4'hF, 2'b01};
      tbl[7] = '{2'b10, 1'b0, 10'd0,    8'd1, 16'hFFF0, 1, 10'd0,    10'd0,    4'hF, 2'b10};

      sys_rst   = 1'b1;
      cmd_valid = 1'b0;
      cmd_dir   = 2'b00;
      cmd_lk0   = 1'b0;
      cmd_base  = '0;
      cmd_rows  = '0;
      c_valid   = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset {crdy,cvrdy,sel,lk,enb,web,addr,done}",
          32'({cmd_ready, c_ready, CB_dinb_sel, l_k_0, CB_enb, CB_web, CB_addrb, done}),
          32'({1'b1, 20'd0}));
      sys_rst = 1'b0;

      // directed table
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < MAXP; k++) vld[k] = (k < 16) ? tbl[i].pat[k] : 1'b1;
         run_cmd(tbl[i].dir, tbl[i].lk0, tbl[i].base, tbl[i].rows, 1'b0, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d summary {n,first,last,web,sel}", i),
             {st_n[5:0], st_first, st_last, st_web, st_sel},
             {tbl[i].n[5:0], tbl[i].first, tbl[i].last, tbl[i].web, tbl[i].sel});
         $display("[TB] tbl%0d dir=%b base=%0d rows=%0d strobes=%0d", i, tbl[i].dir,
                  tbl[i].base, tbl[i].rows, st_n);
      end

      // reset in the middle of a 4-row command, after its first beat
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = 2'b01; cmd_lk0 = 1'b0; cmd_base = 10'd100; cmd_rows = 8'd4;
      @(negedge clk);
      cmd_valid = 1'b0; c_valid = 1'b1;
      @(negedge clk);
      chk("midrst first strobe {enb,addr}", 32'({CB_enb, CB_addrb}), 32'({1'b1, 10'd100}));
      sys_rst = 1'b1;
      @(negedge clk);
      chk("midrst after reset {crdy,cvrdy,sel,lk,enb,web,addr,done}",
          32'({cmd_ready, c_ready, CB_dinb_sel, l_k_0, CB_enb, CB_web, CB_addrb, done}),
          32'({1'b1, 20'd0}));
      sys_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("midrst quiet%0d {crdy,cvrdy,enb,done}", i),
             32'({cmd_ready, c_ready, CB_enb, done}), 32'(4'b1000));
      end
      c_valid = 1'b0;
      $display("[TB] reset mid-run checked");

      // a different command held on cmd_valid while busy must be ignored
      for (int k = 0; k < MAXP; k++) vld[k] = 1'b1;
      run_cmd(2'b01, 1'b0, 10'd50, 8'd3, 1'b1, "hold");
      chk("hold summary {n,first,last}", {st_n[5:0], st_first, st_last},
          {6'd3, 10'd50, 10'd52});
      @(negedge clk);
      chk("hold stays idle {crdy,cvrdy,sel,enb}",
          32'({cmd_ready, c_ready, CB_dinb_sel, CB_enb}), 32'(5'b10000));
      $display("[TB] held command ignored while busy");

      // random commands
      for (int r = 0; r < 24; r++) begin
         logic [1:0] rdir;
         logic       rlk;
         logic [9:0] rbase;
         logic [7:0] rrows;
         bit         rhold;
         rdir  = 2'($urandom_range(0, 3));
         rlk   = 1'($urandom_range(0, 1));
         rbase = 10'($urandom_range(0, 1023));
         rrows = 8'($urandom_range(0, 12));
         rhold = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < MAXP; k++) vld[k] = (k < 60) ? ($urandom_range(0, 2) != 0) : 1'b1;
         run_cmd(rdir, rlk, rbase, rrows, rhold, $sformatf("rnd%0d", r));
         $display("[TB] rnd%0d dir=%b lk0=%b base=%0d rows=%0d hold=%0d strobes=%0d",
                  r, rdir, rlk, rbase, rrows, rhold, st_n);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cb_dinb_seq.md
Name: cb_dinb_seq

Overview:
- Sequencer for the covariance-block (CB) BRAM port-B write path.
- Accepts one write command (direction mode, lane half, base address, row count), then consumes the C-result stream one row per handshake.
- Drives the direction select and lane-half bit of the registered lane mapper.
- Emits port-B enable, per-lane write mask and address, delayed one cycle to line up with the mapper's registered output.

Parameters:
- L, 4, number of lanes / RSA_DW-wide words per CB row (NEW-mode masking defined for L=4)
- ADDR_W, 10, CB port-B address width
- CNT_W, 8, row-count width (max rows per command = 2^CNT_W-1)

Ports:
- clk  in  1  system clock
- sys_rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_dir  in  2  00 IDLE(illegal, treated as POS), 01 POS, 10 NEG, 11 NEW
- cmd_lk0  in  1  NEW-mode lane half: 1 = lanes 0-1, 0 = lanes 2-3
- cmd_base  in  ADDR_W  first row address
- cmd_rows  in  CNT_W  number of rows to write
- c_valid  in  1  C row available on mapper input
- c_ready  out  1  row consumed this cycle
- CB_dinb_sel  out  2  mapper direction select
- l_k_0  out  1  mapper lane-half bit
- CB_enb  out  1  port-B enable
- CB_web  out  L  per-lane write enable
- CB_addrb  out  ADDR_W  port-B address
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE. cmd_ready=1 after reset. All other outputs 0, internal counters 0. Reset mid-command abandons it: no further strobes, no done.
- Command accept: in IDLE, cmd_valid&cmd_ready. Latch dir (00 mapped to 01), lk0, base, rows.
  - rows≠0 → RUN.
  - rows=0 → DRAIN with no beat (done only).
- CB_dinb_sel / l_k_0: registered.
  - Equal to the latched dir/lk0 from the cycle after accept through the last RUN cycle.
  - 00 / 0 otherwise.
- RUN:
  - c_ready=1. A beat is c_valid&c_ready at cycle t.
  - Beat k (k=0..rows-1) targets addr = base+k for POS/NEW, base-k for NEG, modulo 2^ADDR_W (wraps silently).
  - c_valid low stalls; counter and address hold; no strobe.
- Write strobe (cycle t+1 of each beat, registered): CB_enb=1, CB_addrb=beat address.
  - CB_web: all ones for POS/NEG.
  - NEW with lk0=1: 4'b0011. NEW with lk0=0: 4'b1100.
  - All three strobe outputs return to 0 in non-strobe cycles.
- Last beat (k=rows-1) accepted at t:
  - State → DRAIN at t+1; c_ready=0 from t+1.
  - DRAIN cycle: final strobe and done=1 together. Next cycle → IDLE, cmd_ready=1.
- Latency: command accept to first possible beat = 1 cycle. Beat to strobe = 1. Last beat to done = 1. Last beat to next cmd_ready = 2.
- Simultaneous events:
  - cmd_valid in any non-IDLE state is ignored (cmd_ready=0).
  - c_valid outside RUN is ignored (c_ready=0).
- Counter: rows-remaining decrements per beat; RUN exits on the beat where remaining==1.

Decomposition:
- Shared package: DIR_IDLE/POS/NEG/NEW 2-bit codes (same encoding the mapper decodes), state encoding IDLE/RUN/DRAIN, NEW-mode lane masks.
- One natural sub-module: cb_addr_gen (base load, ±1 step per beat, wrap), reusable by the port-A sequencer.

Test Plan:
- POS: base=5, rows=3, c_valid held high → strobes at addr 5,6,7 on consecutive cycles, web=1111, sel=01; done with the addr-7 strobe; cmd_ready one cycle later.
- NEG: base=2, rows=4 → addr 2,1,0,1023 (wrap), sel=10, web=1111, exactly 4 strobes.
- NEW: lk0=1, base=9, rows=2 → addr 9,10, web=0011, l_k_0=1. Repeat with lk0=0 → web=1100, l_k_0=0.
- Stall: POS rows=3, c_valid pattern 1,0,0,1,1 → strobes only one cycle after each high beat, addr 0,1,2, done after third; c_ready drops after third beat.
- rows=0: single command → done one cycle after accept, CB_enb never asserted, sel stays 00.
- Reset mid-RUN after 1 of 4 beats: next cycle all outputs 0, cmd_ready=1, no done. Then cmd_valid held during RUN of a new command is ignored until done.
